// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary frame counter.
// The state enum is common to the top and the bench; countWidth sizes the
// popcount result so that an all-ones frame of WIDTH bits never wraps.
package unary_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } frameState_e;

    function automatic int countWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/unary_popcount.sv
// Parameterised combinational popcount.
// Each bit is zero-extended to CW bits before summing, so the result for
// an all-ones input is exactly WIDTH.
module unary_popcount #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    // Sum the ones of the frame.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule

// File: rtl/unary_frame_counter.sv
// Unary frame counter: follows the shift strobes of an upstream shift
// register, captures each completed frame with its popcount into a
// one-entry output buffer, and flags frames dropped while the buffer is full.
// Optional feature: define UNARY_THERMO_CHECK_EN to add the thermo_err
// output, which marks captured frames that are not thermometer coded.
module unary_frame_counter
    import unary_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = countWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word,
    output logic [CW-1:0]    out_count,
    output logic             overflow
`ifdef UNARY_THERMO_CHECK_EN
    ,
    output logic             thermo_err
`endif
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic [BW-1:0]    bitCnt_q, bitCnt_d;
    logic             capPend_q, capPend_d;
    frameState_e      state_q, state_d;
    logic [WIDTH-1:0] outWord_q, outWord_d;
    logic [CW-1:0]    outCount_q, outCount_d;
    logic             overflow_q, overflow_d;
    logic [CW-1:0]    frameCount;
    logic             loadFrame;
`ifdef UNARY_THERMO_CHECK_EN
    logic             thermoErr_q, thermoErr_d;
    logic             notThermo;
`endif

    unary_popcount #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_popcount (
        .data_i  (parallel_in),
        .count_o (frameCount)
    );

    // Track the bit position; the capture request lags the last strobe by one
    // cycle because the upstream register only holds the whole frame after it.
    always_comb begin
        bitCnt_d  = bitCnt_q;
        capPend_d = 1'b0;
        if (shift_en) begin
            capPend_d = (bitCnt_q == LAST_BIT);
            bitCnt_d  = (bitCnt_q == LAST_BIT) ? '0 : bitCnt_q + 1'b1;
        end
    end

`ifdef UNARY_THERMO_CHECK_EN
    // A thermometer code never has a 1 sitting directly below a 0.
    always_comb begin
        notThermo = 1'b0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (!parallel_in[i + 1] && parallel_in[i]) begin
                notThermo = 1'b1;
            end
        end
    end
`endif

    // Output buffer control: load when empty or when the held word is being
    // accepted in the same cycle, otherwise drop the new frame and flag it.
    always_comb begin
        state_d    = state_q;
        outWord_d  = outWord_q;
        outCount_d = outCount_q;
        overflow_d = overflow_q;
        loadFrame  = 1'b0;
`ifdef UNARY_THERMO_CHECK_EN
        thermoErr_d = thermoErr_q;
`endif
        case (state_q)
            EMPTY: begin
                if (capPend_q) begin
                    loadFrame = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (capPend_q) begin
                    if (out_ready) begin
                        loadFrame = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (loadFrame) begin
            outWord_d  = parallel_in;
            outCount_d = frameCount;
`ifdef UNARY_THERMO_CHECK_EN
            thermoErr_d = notThermo;
`endif
        end
    end

    // State and data registers, all cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt_q   <= '0;
            capPend_q  <= 1'b0;
            state_q    <= EMPTY;
            outWord_q  <= '0;
            outCount_q <= '0;
            overflow_q <= 1'b0;
`ifdef UNARY_THERMO_CHECK_EN
            thermoErr_q <= 1'b0;
`endif
        end else begin
            bitCnt_q   <= bitCnt_d;
            capPend_q  <= capPend_d;
            state_q    <= state_d;
            outWord_q  <= outWord_d;
            outCount_q <= outCount_d;
            overflow_q <= overflow_d;
`ifdef UNARY_THERMO_CHECK_EN
            thermoErr_q <= thermoErr_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_word  = outWord_q;
    assign out_count = outCount_q;
    assign overflow  = overflow_q;
`ifdef UNARY_THERMO_CHECK_EN
    assign thermo_err = thermoErr_q;
`endif

endmodule

// File: tb/tb_unary_frame_counter.sv
// Self-checking bench for unary_frame_counter (WIDTH=4).
// The bench owns the upstream shift register and a reference model that
// reconstructs each frame from the serial bits it sent.
// Define UNARY_THERMO_CHECK_EN to also check thermo_err.
module tb_unary_frame_counter;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             shift_en = 1'b0;
    logic [WIDTH-1:0] parallel_in = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_word;
    logic [CW-1:0]    out_count;
    logic             overflow;
`ifdef UNARY_THERMO_CHECK_EN
    logic             thermo_err;
`endif

    int testCount = 0;
    int failCount = 0;

    // Reference model state
    int mStrobes;
    bit mPend;
    int mPendWord;
    bit mValid;
    int mWord;
    bit mOvf;
    int recentBits[$];

    unary_frame_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (shift_en),
        .parallel_in (parallel_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_word    (out_word),
        .out_count   (out_count),
        .overflow    (overflow)
`ifdef UNARY_THERMO_CHECK_EN
        ,
        .thermo_err  (thermo_err)
`endif
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic int onesOf(input int v);
        int n = 0;
        int x = v;
        for (int i = 0; i < WIDTH; i++) begin
            n += x % 2;
            x = x / 2;
        end
        return n;
    endfunction

    function automatic bit isThermo(input int v);
        for (int k = 0; k <= WIDTH; k++) begin
            if (v == (((1 << k) - 1) << (WIDTH - k))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mStrobes  = 0;
        mPend     = 1'b0;
        mPendWord = 0;
        mValid    = 1'b0;
        mWord     = 0;
        mOvf      = 1'b0;
        recentBits.delete();
    endtask

    // Advance the model by one clock edge using the inputs seen before it.
    task automatic modelEdge(input bit se, input bit b, input bit rdy);
        if (mPend) begin
            if (!mValid || rdy) begin
                mValid = 1'b1;
                mWord  = mPendWord;
            end else begin
                mOvf = 1'b1;
            end
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
        mPend = 1'b0;
        if (se) begin
            recentBits.push_back(int'(b));
            if (recentBits.size() > WIDTH) void'(recentBits.pop_front());
            mStrobes++;
            if (mStrobes % WIDTH == 0) begin
                mPend     = 1'b1;
                mPendWord = 0;
                foreach (recentBits[i]) mPendWord = mPendWord * 2 + recentBits[i];
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("valid", out_valid, mValid);
        checkOutput("overflow", overflow, mOvf);
        if (mValid) begin
            checkOutput("word", out_word, mWord);
            checkOutput("count", out_count, onesOf(mWord));
`ifdef UNARY_THERMO_CHECK_EN
            checkOutput("thermo", thermo_err, !isThermo(mWord));
`endif
        end
    endtask

    // Drive one cycle of inputs, clock it, shift the upstream register and check.
    task automatic applyStimulus(input bit se, input bit b, input bit rdy);
        shift_en  = se;
        out_ready = rdy;
        @(posedge clk);
        #1;
        if (se) parallel_in = {parallel_in[WIDTH-2:0], b};
        modelEdge(se, b, rdy);
        checkModel();
    endtask

    // Pulse reset low between edges and check that outputs clear at once.
    task automatic pulseReset();
        rst_n = 1'b1;
        #1;
        rst_n     = 1'b0;
        shift_en  = 1'b0;
        out_ready = 1'b0;
        #2;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_word", out_word, 0);
        checkOutput("rst_count", out_count, 0);
        checkOutput("rst_overflow", overflow, 0);
`ifdef UNARY_THERMO_CHECK_EN
        checkOutput("rst_thermo", thermo_err, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic shiftFrame(input logic [WIDTH-1:0] frame, input bit rdy);
        for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(1'b1, frame[i], rdy);
    endtask

    initial begin
        modelReset();
        pulseReset();

        // Frame 1,1,1,0 with the consumer always ready.
        shiftFrame(4'b1110, 1'b1);
        checkOutput("r030_pending_valid", out_valid, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r030_valid", out_valid, 1);
        checkOutput("r030_word", out_word, 4'b1110);
        checkOutput("r030_count", out_count, 3);
`ifdef UNARY_THERMO_CHECK_EN
        checkOutput("r030_thermo", thermo_err, 0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r030_accepted", out_valid, 0);

        // Two frames while stalled: the second is dropped.
        pulseReset();
        shiftFrame(4'b1111, 1'b0);
        shiftFrame(4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("r031_word", out_word, 4'b1111);
        checkOutput("r031_count", out_count, 4);
        checkOutput("r031_overflow", overflow, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r031_valid", out_valid, 0);
        checkOutput("r031_sticky", overflow, 1);

        // Next frame arrives exactly as the held one is accepted.
        pulseReset();
        shiftFrame(4'b1010, 1'b0);
        shiftFrame(4'b0011, 1'b0);
        checkOutput("r032_first", out_word, 4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r032_valid", out_valid, 1);
        checkOutput("r032_word", out_word, 4'b0011);
        checkOutput("r032_count", out_count, 2);
        checkOutput("r032_overflow", overflow, 0);

        // Reset in mid-frame while a word is held.
        pulseReset();
        shiftFrame(4'b0111, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("r033_held", out_valid, 1);
        pulseReset();
        shiftFrame(4'b1000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("r033_word", out_word, 4'b1000);
        checkOutput("r033_count", out_count, 1);

        // Non-thermometer frame.
        pulseReset();
        shiftFrame(4'b0110, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("r034_word", out_word, 4'b0110);
        checkOutput("r034_count", out_count, 2);
`ifdef UNARY_THERMO_CHECK_EN
        checkOutput("r034_thermo", thermo_err, 1);
`endif

        // Strobes every other cycle.
        pulseReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("r035_latency", out_valid, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("r035_valid", out_valid, 1);
        checkOutput("r035_count", out_count, 2);

        // Randomized traffic against the model, with one reset in the middle.
        pulseReset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) pulseReset();
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/unary_frame_counter.md
UNARY_FRAME_COUNTER -- requirements
Module: unary_frame_counter

Interface
REQ-001 Parameter WIDTH, default 4, is the frame length in bits and equals the width of the upstream shift register; legal values are WIDTH >= 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port shift_en, input, 1 bit: the same shift-enable strobe that drives the upstream shift register.
REQ-005 Port parallel_in, input, WIDTH bits: the upstream shift-register contents; the first-received bit sits at the MSB once a frame is complete.
REQ-006 Port out_ready, input, 1 bit: the consumer accepts the current output.
REQ-007 Port out_valid, output, 1 bit: out_word and out_count hold a captured frame.
REQ-008 Port out_word, output, WIDTH bits: the captured frame.
REQ-009 Port out_count, output, CW bits: the number of 1s in out_word, where CW = clog2(WIDTH+1).
REQ-010 Port overflow, output, 1 bit: sticky flag, set when a frame has been dropped.
REQ-011 Port thermo_err, output, 1 bit: present only when UNARY_THERMO_CHECK_EN is defined (see Configuration).

Function
REQ-012 The block SHALL keep a bit counter bit_cnt, range 0..WIDTH-1, that increments on each cycle with shift_en=1 and wraps from WIDTH-1 to 0.
REQ-013 A cycle with shift_en=1 and bit_cnt=WIDTH-1 SHALL set cap_pend=1 for exactly the next cycle, because the upstream register holds the complete frame only after that edge.
REQ-014 State machine states are EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 EMPTY with cap_pend=1: the block SHALL register out_word<=parallel_in and out_count<=popcount(parallel_in), then move to FULL; capture latency is 2 edges after the final shift strobe.
REQ-016 FULL with out_ready=1 and cap_pend=0: the block SHALL move to EMPTY.
REQ-017 FULL with out_ready=1 and cap_pend=1: the block SHALL load the new frame, stay in FULL, and leave overflow unchanged.
REQ-018 FULL with out_ready=0 and cap_pend=1: the block SHALL drop the new frame, keep out_word and out_count unchanged, and set overflow=1.
REQ-019 In FULL, out_word and out_count SHALL remain stable until accepted.
REQ-020 overflow SHALL clear only on reset.
REQ-021 Cycles with shift_en=0 SHALL hold bit_cnt; gaps between strobes are unbounded.
REQ-022 out_count SHALL be computed zero-extended to CW bits and SHALL never wrap; all-ones gives WIDTH.

Reset
REQ-023 When rst_n=0, the block SHALL immediately force bit_cnt=0, cap_pend=0, state=EMPTY, out_valid=0, out_word=0, out_count=0, overflow=0, thermo_err=0.
REQ-024 A reset in mid-frame SHALL discard the partial frame; counting restarts from bit 0 after release.

Configuration
REQ-025 Macro UNARY_THERMO_CHECK_EN, when defined: on each capture, thermo_err SHALL be registered to 1 if parallel_in is not a valid thermometer code, i.e. not of the form k ones at the MSB end followed by zeros, with 0 <= k <= WIDTH; otherwise it SHALL be registered to 0.
REQ-026 Under UNARY_THERMO_CHECK_EN, thermo_err SHALL be updated in the same cycle as out_word and SHALL hold while in FULL.
REQ-027 When UNARY_THERMO_CHECK_EN is not defined: the thermo_err port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-028 Package unary_pkg SHALL hold the state enum (EMPTY, FULL) and a function returning CW for a given WIDTH.
REQ-029 One sub-module, unary_popcount, SHALL provide the parameterised combinational popcount; the thermometer check stays inline.

Verification (WIDTH=4)
REQ-030 Shift serial 1,1,1,0 with out_ready=1 -> 2 edges after the 4th strobe: out_valid=1, out_word=4'b1110, out_count=3, thermo_err=0; the next cycle gives out_valid=0.
REQ-031 Hold out_ready=0 across two full frames, 1111 then 0000 -> out_word=4'b1111, out_count=4, overflow=1; raising out_ready clears out_valid, and overflow stays 1.
REQ-032 Frame 2 completes (cap_pend=1) in the same cycle out_ready=1 accepts frame 1 -> frame 2 is loaded, out_valid stays 1, overflow=0.
REQ-033 Strobes for 2 bits, then rst_n pulsed low mid-cycle -> all outputs 0 asynchronously; after release, a full 1,0,0,0 frame yields out_word=4'b1000, out_count=1.
REQ-034 Frame 0,1,1,0 under UNARY_THERMO_CHECK_EN -> out_word=4'b0110, out_count=2, thermo_err=1.
REQ-035 shift_en=1 every other cycle for frame 1,1,0,0 -> capture occurs 2 edges after the 4th strobe, out_count=2.
